iir_output_requantizer: RTL and testbench
=========================================

Name: iir_output_requantizer

Overview:
- Sits directly downstream of FixedPoint_IIR_SOS_Filter. Consumes its wide Filt_Out word (Q8.18) and its overFlow flag.
- Rounds the word to a narrower output format, saturates it, and buffers the results in a small FIFO.
- Presents the buffered samples on a ready/valid interface to the DAC/packetiser stage.
- Keeps sticky overflow status plus saturation and drop counters for software.

Parameters:
- WI_OUT, 8, integer bits of the input word (must match the filter's WI_OUT)
- WF_OUT, 18, fraction bits of the input word (must match the filter's WF_OUT)
- WI_Q, 3, integer bits of the output word; legal only if WI_Q <= WI_OUT
- WF_Q, 13, fraction bits of the output word; legal only if WF_Q < WF_OUT
- DEPTH, 8, FIFO depth in entries; must be a power of two, minimum 2
- CNT_W, 8, width of the statistics counters

Ports:
- CLK  in  1  the single clock; all logic on its rising edge
- nReset  in  1  synchronous, active-low reset
- in_valid  in  1  Filt_Out/overFlow hold a new sample this cycle
- Filt_Out  in  WI_OUT+WF_OUT  two's-complement filter output, Q(WI_OUT).(WF_OUT)
- overFlow  in  1  filter overflow flag, qualified by in_valid
- out_data  out  WI_Q+WF_Q  FIFO head sample, Q(WI_Q).(WF_Q)
- out_sat  out  1  the head sample was saturated or carried overFlow
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts the head this cycle
- clr_stats  in  1  synchronous clear of the sticky flag and counters
- sticky_ovf  out  1  set by any sample with overFlow=1 or a saturation
- sat_count  out  CNT_W  saturated-sample count, stops at all-ones
- drop_count  out  CNT_W  samples lost to a full FIFO, stops at all-ones

Behaviour:

Reset (nReset=0 at a rising edge):
- FIFO empty, pointers 0, pipeline valids 0.
- out_valid=0, out_data=0, out_sat=0, sticky_ovf=0, sat_count=0, drop_count=0.
- Reset wins over every other input. A reset in the middle of a stream discards both pipeline stages and all FIFO contents.

Stage 1, rounding (register):
- Let SH = WF_OUT-WF_Q.
- Sign-extend the input by 1 bit, add 2^(SH-1) (round half up, toward +inf), then arithmetic-shift right by SH.
- The result is WI_OUT+WF_Q+1 bits wide.
- overFlow and in_valid are registered alongside.

Stage 2, saturation (register):
- MAX = 2^(WI_Q+WF_Q-1)-1, MIN = -2^(WI_Q+WF_Q-1).
- A result above MAX clamps to MAX; below MIN clamps to MIN. The sat bit is 1 when clamped OR when the registered overFlow is 1.
- The data and sat bit form a (WI_Q+WF_Q+1)-bit FIFO word.

Latency:
- A sample presented with in_valid in cycle N is written into the FIFO at the edge ending cycle N+2.
- An empty FIFO raises out_valid in cycle N+3. There is no bypass.
- Back-to-back in_valid is sustained at 1 sample per clock.

FIFO:
- Show-ahead: out_data/out_sat always reflect the head entry while out_valid=1.
- Pop occurs when out_valid & out_ready.
- Push is accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle.
- Otherwise the sample is dropped and drop_count increments.
- Simultaneous push and pop leave the occupancy unchanged.
- Pointers are log2(DEPTH)+1 bits and wrap naturally; full/empty come from the MSB comparison.
- out_data holds its value while out_valid=0. Its content is don't-care.

Statistics:
- sat_count increments once per stage-2 valid sample with sat=1, whether or not that sample is later dropped.
- sticky_ovf sets on the same condition.
- Both counters stop at 2^CNT_W-1.
- If clr_stats coincides with an increment event, clr_stats wins: the result is 0/0/0 and that event is not counted.

The pipeline has no backpressure toward the filter, because the filter produces one sample per clock unconditionally.

Test Plan:
1. Reset, then in_valid=1 with Filt_Out=0x0040000 (+1.0) and out_ready=1 -> out_valid rises 3 cycles later with out_data=0x2000 and out_sat=0.
2. Rounding: input 0x0000010 (+half LSB) -> 0x0001. Input 0x3FFFFF0 (-half LSB) -> 0x0000. Input 0x000000F -> 0x0000. All with out_sat=0.
3. Saturation:
   - 0x0140000 (+5.0) -> 0x7FFF, out_sat=1.
   - 0x3E80000 (-6.0) -> 0x8000, out_sat=1.
   - 0x00FFFF0 (rounds to +4.0) -> 0x7FFF, out_sat=1.
   - After these, sat_count=3 and sticky_ovf=1.
4. overFlow=1 with Filt_Out=0x0040000 -> out_data=0x2000, out_sat=1, sat_count increments. Then clr_stats -> sticky_ovf=0, sat_count=0, drop_count=0 on the next cycle.
5. Hold out_ready=0 and stream 12 samples (values 1..12 in LSB-aligned Q3.13, i.e. inputs k<<5):
   - FIFO holds 8 samples and drop_count=4.
   - Raising out_ready drains 1..8 in order, one per clock.
   - Full with push and pop in the same cycle -> no drop, order preserved.
6. Assert nReset=0 for one edge mid-stream with 5 samples queued -> out_valid=0 and counters=0 on the next cycle. Samples arriving after reset release appear with 3-cycle latency.

Source files
------------

// File: rtl/iir_output_requantizer_if.sv
// Sample stream bundle between the IIR filter, the requantizer and the
// downstream DAC/packetiser: filter-side sample strobe plus the buffered
// ready/valid output.
`timescale 1ns/1ps
interface iir_output_requantizer_if #(
  parameter int IN_W  = 26,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic [IN_W-1:0]  Filt_Out;
  logic             overFlow;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;
  logic             out_valid;
  logic             out_ready;

  // Environment side: produces filter samples, consumes the output stream.
  modport master (
    output in_valid, Filt_Out, overFlow, out_ready,
    input  out_data, out_sat, out_valid
  );

  // Requantizer side.
  modport slave (
    input  in_valid, Filt_Out, overFlow, out_ready,
    output out_data, out_sat, out_valid
  );
endinterface

// File: rtl/iir_output_requantizer.sv
// Requantizes the wide Q(WI_OUT).(WF_OUT) IIR output to Q(WI_Q).(WF_Q):
// round half up, saturate, buffer in a show-ahead FIFO, and keep sticky
// overflow status plus saturation/drop counters.
`timescale 1ns/1ps
module iir_output_requantizer #(
  parameter int WI_OUT = 8,
  parameter int WF_OUT = 18,
  parameter int WI_Q   = 3,
  parameter int WF_Q   = 13,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                        CLK,
  input  logic                        nReset,
  iir_output_requantizer_if.slave     bus,
  input  logic                        clr_stats,
  output logic                        sticky_ovf,
  output logic [CNT_W-1:0]            sat_count,
  output logic [CNT_W-1:0]            drop_count
);

  localparam int IN_W   = WI_OUT + WF_OUT;
  localparam int OUT_W  = WI_Q + WF_Q;
  localparam int SH     = WF_OUT - WF_Q;
  localparam int RND_W  = WI_OUT + WF_Q + 1;
  localparam int WORD_W = OUT_W + 1;
  localparam int AW     = $clog2(DEPTH);

  localparam logic [IN_W:0] HALF_LSB = (IN_W+1)'(1) << (SH - 1);
  localparam logic signed [RND_W-1:0] MAX_V =
    {{(RND_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RND_W-1:0] MIN_V =
    {{(RND_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // ---------------- Stage 1: round half up ----------------
  logic [IN_W:0]      ext_sum;
  logic               s1_valid;
  logic               s1_ovf;
  logic [RND_W-1:0]   s1_data;

  // One guard bit of sign extension keeps the rounding add from wrapping;
  // slicing off the low SH bits is the arithmetic shift.
  assign ext_sum = {bus.Filt_Out[IN_W-1], bus.Filt_Out} + HALF_LSB;

  // Register the rounded word with its qualifiers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!nReset) begin
      s1_valid <= 1'b0;
      s1_ovf   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      s1_ovf   <= bus.overFlow;
      s1_data  <= ext_sum[IN_W:SH];
    end
  end

  // ---------------- Stage 2: saturate ----------------
  logic [OUT_W-1:0]   sat_data;
  logic               clamped;
  logic               s2_valid;
  logic [WORD_W-1:0]  s2_word;   // {sat, data}

  // Clamp the rounded value into the output range.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sat_data = s1_data[OUT_W-1:0];
    clamped  = 1'b0;
    if ($signed(s1_data) > MAX_V) begin
      sat_data = {1'b0, {(OUT_W-1){1'b1}}};
      clamped  = 1'b1;
    end else if ($signed(s1_data) < MIN_V) begin
      sat_data = {1'b1, {(OUT_W-1){1'b0}}};
      clamped  = 1'b1;
    end
  end

  // Register the FIFO word; an upstream overflow also marks the sample.
  always_ff @(posedge CLK) begin
    if (!nReset) begin
      s2_valid <= 1'b0;
      s2_word  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_word  <= {clamped | s1_ovf, sat_data};
    end
  end

  // ---------------- Show-ahead FIFO ----------------
  logic [WORD_W-1:0]  mem [DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr, occ;
  logic [AW-1:0]      rd_idx_nxt;
  logic               empty, full, pop, push, drop, one_left;
  logic [WORD_W-1:0]  head_q, head_d;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign occ        = wr_ptr - rd_ptr;
  assign one_left   = (occ == (AW+1)'(1));
  assign rd_idx_nxt = rd_ptr[AW-1:0] + AW'(1);
  assign pop        = !empty && bus.out_ready;
  assign push       = s2_valid && (!full || pop);
  assign drop       = s2_valid && !push;

  // Next head word: the incoming sample when it lands in an empty (or
  // emptying) FIFO, the following entry after a pop, otherwise unchanged.
  always_comb begin
    head_d = head_q;
    if (empty && push)
      head_d = s2_word;
    else if (pop && one_left && push)
      head_d = s2_word;
    else if (pop && !one_left)
      head_d = mem[rd_idx_nxt];
  end

  // Pointers and the registered head word.
  always_ff @(posedge CLK) begin
    if (!nReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      head_q <= head_d;
    end
  end

  // Storage array write port.
  // NOTE: the array is deliberately left out of reset; the pointers define
  // which entries are valid, so clearing it would only cost logic.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s2_word;
  end

  assign bus.out_valid = !empty;
  assign bus.out_data  = head_q[OUT_W-1:0];
  assign bus.out_sat   = head_q[OUT_W];

  // ---------------- Statistics ----------------
  logic sat_evt;
  assign sat_evt = s2_valid && s2_word[WORD_W-1];

  // Sticky flag and saturating counters; a clear beats a coincident event.
  always_ff @(posedge CLK) begin
    if (!nReset || clr_stats) begin
      sticky_ovf <= 1'b0;
      sat_count  <= '0;
      drop_count <= '0;
    end else begin
      if (sat_evt) sticky_ovf <= 1'b1;
      if (sat_evt && sat_count != '1)   sat_count  <= sat_count + CNT_W'(1);
      if (drop && drop_count != '1)     drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_iir_output_requantizer.sv
// Directed bench for iir_output_requantizer: table of single-sample
// rounding/saturation vectors, then hand sequences for statistics clear,
// counter ceiling, FIFO full/drop/drain and mid-stream reset.
`timescale 1ns/1ps
module tb_iir_output_requantizer;
  localparam int IN_W  = 26;
  localparam int OUT_W = 16;
  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             nReset = 1'b0;
  logic             clr_stats = 1'b0;
  logic             sticky_ovf;
  logic [CNT_W-1:0] sat_count;
  logic [CNT_W-1:0] drop_count;

  iir_output_requantizer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  iir_output_requantizer dut (
    .CLK        (CLK),
    .nReset     (nReset),
    .bus        (bus),
    .clr_stats  (clr_stats),
    .sticky_ovf (sticky_ovf),
    .sat_count  (sat_count),
    .drop_count (drop_count)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [IN_W-1:0]  filt;
    logic             ovf;
    logic [OUT_W-1:0] exp_data;
    logic             exp_sat;
  } vec_t;

  vec_t vecs [11];
  int   exp_order [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [IN_W-1:0] f, input logic o);
    bus.in_valid = v;
    bus.Filt_Out = f;
    bus.overFlow = o;
  endtask

  // One sample into an empty FIFO with out_ready=1: absent after 2 cycles,
  // present after 3, then popped.
  task automatic apply_one(input vec_t v, input string name);
    drive(1'b1, v.filt, v.ovf);
    tick();
    drive(1'b0, '0, 1'b0);
    tick();
    check({name, " early valid"}, 32'(bus.out_valid), 32'd0);
    tick();
    check({name, " valid"}, 32'(bus.out_valid), 32'd1);
    check({name, " data"},  32'(bus.out_data),  32'(v.exp_data));
    check({name, " sat"},   32'(bus.out_sat),   32'(v.exp_sat));
    tick();
  endtask

  initial begin
    vecs[0]  = '{26'h0040000, 1'b0, 16'h2000, 1'b0};  // +1.0
    vecs[1]  = '{26'h0000010, 1'b0, 16'h0001, 1'b0};  // +half LSB rounds up
    vecs[2]  = '{26'h3FFFFF0, 1'b0, 16'h0000, 1'b0};  // -half LSB rounds to 0
    vecs[3]  = '{26'h000000F, 1'b0, 16'h0000, 1'b0};  // just below half
    vecs[4]  = '{26'h3FFFFEF, 1'b0, 16'hFFFF, 1'b0};  // just below -half
    vecs[5]  = '{26'h3FC0000, 1'b0, 16'hE000, 1'b0};  // -1.0
    vecs[6]  = '{26'h00FFFE0, 1'b0, 16'h7FFF, 1'b0};  // rounds exactly to MAX
    vecs[7]  = '{26'h3F00000, 1'b0, 16'h8000, 1'b0};  // exactly MIN (-4.0)
    vecs[8]  = '{26'h0140000, 1'b0, 16'h7FFF, 1'b1};  // +5.0 clamps
    vecs[9]  = '{26'h3E80000, 1'b0, 16'h8000, 1'b1};  // -6.0 clamps
    vecs[10] = '{26'h00FFFF0, 1'b0, 16'h7FFF, 1'b1};  // rounds to +4.0, clamps
    exp_order = '{1, 2, 3, 4, 5, 6, 7, 8, 13, 14, 15};

    drive(1'b0, '0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    nReset = 1'b1;

    // Reset state
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_data",  32'(bus.out_data),  32'd0);
    check("rst out_sat",   32'(bus.out_sat),   32'd0);
    check("rst sticky",    32'(sticky_ovf),    32'd0);
    check("rst sat_count", 32'(sat_count),     32'd0);
    check("rst drop_count",32'(drop_count),    32'd0);

    // Non-saturating table entries
    for (int i = 0; i < 8; i++) apply_one(vecs[i], $sformatf("vec%0d", i));
    check("no-sat sticky",    32'(sticky_ovf), 32'd0);
    check("no-sat sat_count", 32'(sat_count),  32'd0);

    // Saturating table entries
    for (int i = 8; i < 11; i++) apply_one(vecs[i], $sformatf("vec%0d", i));
    check("sat sat_count",  32'(sat_count),  32'd3);
    check("sat sticky",     32'(sticky_ovf), 32'd1);
    check("sat drop_count", 32'(drop_count), 32'd0);

    // Upstream overflow marks an in-range sample
    apply_one('{26'h0040000, 1'b1, 16'h2000, 1'b1}, "ovf");
    check("ovf sat_count", 32'(sat_count), 32'd4);

    // Clear coinciding with a saturation event: clear wins, sample still queued
    drive(1'b1, 26'h0140000, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    tick();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr sat_count",  32'(sat_count),     32'd0);
    check("clr sticky",     32'(sticky_ovf),    32'd0);
    check("clr drop_count", 32'(drop_count),    32'd0);
    check("clr sample",     32'(bus.out_data),  32'h7FFF);
    check("clr sample sat", 32'(bus.out_sat),   32'd1);
    tick();

    // Counter ceiling: 260 saturating samples stop at all-ones
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 26'h0140000, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    tick();
    check("ceiling sat_count",  32'(sat_count),  32'd255);
    check("ceiling drop_count", 32'(drop_count), 32'd0);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr2 sat_count", 32'(sat_count),     32'd0);
    check("clr2 empty",     32'(bus.out_valid), 32'd0);

    // FIFO full with out_ready=0: 12 samples, 8 kept, 4 dropped
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, IN_W'(k) << 5, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    check("full drop_count", 32'(drop_count),    32'd4);
    check("full valid",      32'(bus.out_valid), 32'd1);
    check("full head",       32'(bus.out_data),  32'd1);

    // Push into a full FIFO coinciding with pops, then drain
    drive(1'b1, IN_W'(13) << 5, 1'b0);
    tick();
    drive(1'b1, IN_W'(14) << 5, 1'b0);
    tick();
    drive(1'b1, IN_W'(15) << 5, 1'b0);
    bus.out_ready = 1'b1;
    check("drain 0", 32'(bus.out_data), 32'(exp_order[0]));
    tick();
    drive(1'b0, '0, 1'b0);
    for (int i = 1; i < 11; i++) begin
      check($sformatf("drain %0d valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("drain %0d", i), 32'(bus.out_data), 32'(exp_order[i]));
      tick();
    end
    check("drained empty",      32'(bus.out_valid), 32'd0);
    check("drained drop_count", 32'(drop_count),    32'd4);

    // Mid-stream reset with 5 queued and both pipeline stages busy
    bus.out_ready = 1'b0;
    for (int k = 20; k < 24; k++) begin
      drive(1'b1, IN_W'(k) << 5, 1'b0);
      tick();
    end
    drive(1'b1, 26'h0140000, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    check("pre-rst valid",     32'(bus.out_valid), 32'd1);
    check("pre-rst sat_count", 32'(sat_count),     32'd1);
    drive(1'b1, IN_W'(24) << 5, 1'b0);
    tick();
    drive(1'b1, IN_W'(25) << 5, 1'b0);
    tick();
    drive(1'b1, IN_W'(26) << 5, 1'b0);
    nReset = 1'b0;
    tick();
    nReset = 1'b1;
    drive(1'b0, '0, 1'b0);
    check("mid-rst valid",      32'(bus.out_valid), 32'd0);
    check("mid-rst data",       32'(bus.out_data),  32'd0);
    check("mid-rst sticky",     32'(sticky_ovf),    32'd0);
    check("mid-rst sat_count",  32'(sat_count),     32'd0);
    check("mid-rst drop_count", 32'(drop_count),    32'd0);
    tick();
    tick();
    tick();
    check("post-rst flushed", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    apply_one(vecs[0], "post-rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
